// File: rtl/qpsk_modulator_if.sv
// Symbol input handshake plus I/Q sample output of the QPSK modulator.
// master = symbol source / sample sink, slave = the modulator.
interface qpsk_modulator_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]                   bit_in;
  logic                         bit_in_valid;
  logic                         bit_in_ready;
  logic                         tx_en;
  logic signed [DATA_WIDTH-1:0] i_data;
  logic signed [DATA_WIDTH-1:0] q_data;
  logic                         iq_valid;
  logic                         busy;
  logic                         underrun;

  modport master (
    output bit_in, bit_in_valid, tx_en,
    input  bit_in_ready, i_data, q_data, iq_valid, busy, underrun
  );

  modport slave (
    input  bit_in, bit_in_valid, tx_en,
    output bit_in_ready, i_data, q_data, iq_valid, busy, underrun
  );
endinterface

// File: rtl/qpsk_modulator.sv
// QPSK modulator: 2-bit symbols buffered in a small FIFO, mapped to +/-A I/Q
// points and held for SPS samples each; quadrant mapping matches the receiver.
module qpsk_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int AMPLITUDE  = 4096,
  parameter int SPS        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  qpsk_modulator_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic signed [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(AMPLITUDE);
  localparam logic signed [DATA_WIDTH-1:0] AMP_N = -AMP_P;

  logic [1:0]                   mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic [0:0]                   state;
  logic [7:0]                   cnt;
  logic signed [DATA_WIDTH-1:0] i_reg, q_reg;
  logic                         vld_reg, under_reg;
  logic                         ready, push, pop, last;
  logic [1:0]                   head;

  function automatic logic signed [DATA_WIDTH-1:0] level(input logic neg);
    return neg ? AMP_N : AMP_P;
  endfunction

  // No bypass: a full FIFO refuses a push even when a pop happens this cycle.
  assign ready = !reset && (count != CW'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];
  assign last  = (cnt == 8'(SPS - 1));

  always_comb begin
    push = bus.bit_in_valid && ready;
    pop  = 1'b0;
    if (!reset && bus.tx_en && (count != '0))
      pop = (state == IDLE) || last;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.bit_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      i_reg     <= '0;
      q_reg     <= '0;
      vld_reg   <= 1'b0;
      under_reg <= 1'b0;
    end else begin
      under_reg <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (pop) begin
        // bit[0] negates I, bit[1] negates Q
        state   <= SEND;
        i_reg   <= level(head[0]);
        q_reg   <= level(head[1]);
        vld_reg <= 1'b1;
        cnt     <= '0;
      end else if (state == SEND) begin
        if (!last) begin
          cnt <= cnt + 8'd1;
        end else begin
          state     <= IDLE;
          i_reg     <= '0;
          q_reg     <= '0;
          vld_reg   <= 1'b0;
          cnt       <= '0;
          under_reg <= bus.tx_en;
        end
      end
    end
  end

  assign bus.bit_in_ready = ready;
  assign bus.i_data       = i_reg;
  assign bus.q_data       = q_reg;
  assign bus.iq_valid     = vld_reg;
  assign bus.busy         = (state == SEND);
  assign bus.underrun     = under_reg;
endmodule

// File: tb/tb_qpsk_modulator.sv
// Scoreboard bench for qpsk_modulator: expected samples queued on accepted
// symbols, compared (and demapped back to bits) as valid samples appear.
module tb_qpsk_modulator;
  localparam int DW = 16, A = 4096, SPS = 4, DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qpsk_modulator_if #(.DATA_WIDTH(DW)) bus ();

  qpsk_modulator #(
    .DATA_WIDTH(DW), .AMPLITUDE(A), .SPS(SPS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int         i;
    int         q;
    logic [1:0] b;
  } samp_t;

  samp_t exp_q[$];
  samp_t cur;
  int    n_chk = 0, n_pass = 0;
  int    n_under = 0, n_burst = 0;
  logic  prev_vld = 1'b0;
  int    u0, b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  function automatic samp_t model(input logic [1:0] b);
    samp_t s;
    s.i = b[0] ? -A : A;
    s.q = b[1] ? -A : A;
    s.b = b;
    return s;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sym(input logic [1:0] b);
    logic acc;
    acc = 1'b0;
    bus.bit_in       = b;
    bus.bit_in_valid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = bus.bit_in_ready;
      step(1);
    end
    bus.bit_in_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
    else for (int k = 0; k < SPS; k++) exp_q.push_back(model(b));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.iq_valid) && t < 1000) begin
      step(1);
      t++;
    end
    step(2);
    chk(tag, exp_q.size(), 0);
  endtask

  // Output monitor: every valid sample must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.iq_valid) begin
        if (!prev_vld) n_burst++;
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("i_data", int'(bus.i_data), cur.i);
          chk("q_data", int'(bus.q_data), cur.q);
          chk("demap_bits", int'({bus.q_data < 0, bus.i_data < 0}), int'(cur.b));
        end
      end
      chk("busy_vs_valid", int'(bus.busy), int'(bus.iq_valid));
      if (bus.underrun) begin
        n_under++;
        chk("underrun_first_idle", int'(prev_vld && !bus.iq_valid), 1);
      end
    end
    prev_vld <= bus.iq_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bit_in       = 2'b00;
    bus.bit_in_valid = 1'b0;
    bus.tx_en        = 1'b0;

    // reset state
    reset = 1'b1;
    step(2);
    chk("rst_i", int'(bus.i_data), 0);
    chk("rst_q", int'(bus.q_data), 0);
    chk("rst_valid", int'(bus.iq_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_underrun", int'(bus.underrun), 0);
    chk("rst_ready", int'(bus.bit_in_ready), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", int'(bus.bit_in_ready), 1);

    // single symbol, latency and underrun
    bus.tx_en = 1'b1;
    u0 = n_under; b0 = n_burst;
    push_sym(2'b00);
    chk("lat_before_pop", int'(bus.iq_valid), 0);
    step(1);
    chk("lat_first_valid", int'(bus.iq_valid), 1);
    chk("lat_first_i", int'(bus.i_data), A);
    drain("single_drain");
    chk("single_underrun", n_under - u0, 1);
    chk("single_bursts", n_burst - b0, 1);

    // four symbols back-to-back, seamless stream
    u0 = n_under; b0 = n_burst;
    push_sym(2'b00); push_sym(2'b01); push_sym(2'b11); push_sym(2'b10);
    drain("b2b_drain");
    chk("b2b_underrun", n_under - u0, 1);
    chk("b2b_bursts", n_burst - b0, 1);

    // fill FIFO with tx disabled, fifth symbol stalls
    bus.tx_en = 1'b0;
    u0 = n_under; b0 = n_burst;
    push_sym(2'b00); push_sym(2'b01); push_sym(2'b10); push_sym(2'b11);
    bus.bit_in = 2'b01;
    bus.bit_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("full_stall_ready", int'(bus.bit_in_ready), 0);
      step(1);
    end
    chk("full_no_output", int'(bus.iq_valid), 0);
    bus.tx_en = 1'b1;
    chk("ready_before_pop", int'(bus.bit_in_ready), 0);
    step(1);
    chk("ready_after_pop", int'(bus.bit_in_ready), 1);
    step(1);
    bus.bit_in_valid = 1'b0;
    for (int k = 0; k < SPS; k++) exp_q.push_back(model(2'b01));
    drain("full_drain");
    chk("full_underrun", n_under - u0, 1);
    chk("full_bursts", n_burst - b0, 1);

    // tx_en dropped mid-symbol: symbol completes, rest stays buffered
    bus.tx_en = 1'b0;
    push_sym(2'b01); push_sym(2'b10); push_sym(2'b11);
    u0 = n_under;
    bus.tx_en = 1'b1;
    step(1);
    chk("midsym_s1_valid", int'(bus.iq_valid), 1);
    step(1);
    bus.tx_en = 1'b0;
    step(6);
    chk("midsym_idle", int'(bus.iq_valid), 0);
    chk("midsym_no_underrun", n_under - u0, 0);
    chk("midsym_buffered", exp_q.size(), 2 * SPS);
    bus.tx_en = 1'b1;
    drain("midsym_drain");
    chk("midsym_final_underrun", n_under - u0, 1);

    // reset during 3rd sample with two symbols queued
    bus.tx_en = 1'b0;
    push_sym(2'b00); push_sym(2'b11); push_sym(2'b10);
    bus.tx_en = 1'b1;
    step(3);
    chk("rstmid_s3_valid", int'(bus.iq_valid), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    u0 = n_under;
    step(1);
    chk("rstmid_i", int'(bus.i_data), 0);
    chk("rstmid_q", int'(bus.q_data), 0);
    chk("rstmid_valid", int'(bus.iq_valid), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_underrun", int'(bus.underrun), 0);
    reset = 1'b0;
    #1;
    step(10);
    chk("rstmid_quiet", int'(bus.iq_valid), 0);
    chk("rstmid_no_underrun", n_under - u0, 0);

    // random 50-symbol stream, demapped back to bits by the monitor
    for (int n = 0; n < 50; n++) begin
      push_sym(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 6));
    end
    drain("rand_drain");
    chk("rand_idle", int'(bus.iq_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
